// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder modelled on the MAX3421E access protocol.
// Holds a 32 x 8 register file that can be reached over SPI and from a local port.
// Every SPI input is oversampled in the Clk domain. No logic runs on SCLK.
module spi_reg_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STATUS_REG  = 25,
  parameter int unsigned IEN_REG     = 26
) (
  input  logic       Clk,
  input  logic       Reset_N,
  input  logic       SPI_CS_N,
  input  logic       SPI_SCLK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  output logic       IRQ,
  input  logic [4:0] LOC_ADDR,
  input  logic [7:0] LOC_WDATA,
  input  logic       LOC_WE,
  output logic [7:0] LOC_RDATA,
  output logic       WR_STROBE,
  output logic [4:0] WR_ADDR
);

  localparam logic [4:0] StatusIdx = 5'(STATUS_REG);
  localparam logic [4:0] IenIdx    = 5'(IEN_REG);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Synchronizer chains; the newest sample enters at bit 0.
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_dly_q;
  logic                   sclk_dly_q;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic [7:0] tx_next_q;
  logic       byte_done_q;   // next SCLK fall loads tx_next instead of shifting
  logic [4:0] addr_q;
  logic       dir_wr_q;
  logic       oe_q;
  logic       wr_strobe_q;
  logic [4:0] wr_addr_q;
  logic [7:0] loc_rdata_q;
  logic       irq_q;

  logic [7:0] regs_q [32];

  logic [7:0] rx_byte;
  logic       last_bit;
  logic       spi_commit;

  // Capture SPI inputs into the Clk domain and keep a delayed copy for edge detection
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge strobes and byte-completion decode
  always_comb begin
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    cs_fall   = cs_dly_q & ~cs_s;
    cs_rise   = ~cs_dly_q & cs_s;
    sclk_rise = ~sclk_dly_q & sclk_s;
    sclk_fall = sclk_dly_q & ~sclk_s;
    rx_byte   = {rx_q[6:0], mosi_s};
    last_bit  = (bit_cnt_q == 3'd7);
    // A CS rise takes priority over everything, so a byte that ends together with CS is dropped
    spi_commit = (state_q == StData) & ~cs_rise & sclk_rise & last_bit & dir_wr_q;
  end

  // Transfer FSM: command decode, rx/tx shifters and the write strobe
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tx_next_q   <= '0;
      byte_done_q <= 1'b0;
      addr_q      <= '0;
      dir_wr_q    <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (cs_rise) begin
        state_q     <= StIdle;
        oe_q        <= 1'b0;
        tx_q        <= '0;
        byte_done_q <= 1'b0;
        bit_cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q     <= StCmd;
              bit_cnt_q   <= '0;
              tx_q        <= regs_q[StatusIdx];
              byte_done_q <= 1'b0;
              oe_q        <= 1'b1;
            end
          end
          StCmd, StData: begin
            if (sclk_rise) begin
              rx_q      <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                byte_done_q <= 1'b1;
                if (state_q == StCmd) begin
                  addr_q    <= rx_byte[7:3];
                  dir_wr_q  <= rx_byte[1];
                  tx_next_q <= rx_byte[1] ? 8'h00 : regs_q[rx_byte[7:3]];
                  state_q   <= StData;
                end else if (dir_wr_q) begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= addr_q;
                end else begin
                  // Same address again: FIFO-style bursts, no auto-increment
                  tx_next_q <= regs_q[addr_q];
                end
              end
            end else if (sclk_fall) begin
              if (byte_done_q) begin
                tx_q        <= tx_next_q;
                byte_done_q <= 1'b0;
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Register file: a local write, overridden by an SPI commit to the same address
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (LOC_WE) begin
        regs_q[LOC_ADDR] <= LOC_WDATA;
      end
      if (spi_commit) begin
        regs_q[addr_q] <= rx_byte;
      end
    end
  end

  // Registered local read port and interrupt level
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      loc_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      loc_rdata_q <= regs_q[LOC_ADDR];
      irq_q       <= |(regs_q[StatusIdx] & regs_q[IenIdx]);
    end
  end

  assign SPI_MISO    = tx_q[7];
  assign SPI_MISO_OE = oe_q;
  assign IRQ         = irq_q;
  assign LOC_RDATA   = loc_rdata_q;
  assign WR_STROBE   = wr_strobe_q;
  assign WR_ADDR     = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder. It drives an SPI master with a 160 ns SCLK period.
module tb_spi_reg_responder;

  localparam int Half = 80;

  logic       Clk = 1'b0;
  logic       Reset_N;
  logic       SPI_CS_N;
  logic       SPI_SCLK;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       SPI_MISO_OE;
  logic       IRQ;
  logic [4:0] LOC_ADDR;
  logic [7:0] LOC_WDATA;
  logic       LOC_WE;
  logic [7:0] LOC_RDATA;
  logic       WR_STROBE;
  logic [4:0] WR_ADDR;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         strobe_cnt = 0;
  logic [4:0] last_addr = '0;

  spi_reg_responder dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .SPI_CS_N   (SPI_CS_N),
    .SPI_SCLK   (SPI_SCLK),
    .SPI_MOSI   (SPI_MOSI),
    .SPI_MISO   (SPI_MISO),
    .SPI_MISO_OE(SPI_MISO_OE),
    .IRQ        (IRQ),
    .LOC_ADDR   (LOC_ADDR),
    .LOC_WDATA  (LOC_WDATA),
    .LOC_WE     (LOC_WE),
    .LOC_RDATA  (LOC_RDATA),
    .WR_STROBE  (WR_STROBE),
    .WR_ADDR    (WR_ADDR)
  );

  always #5 Clk = ~Clk;

  // Count the cycles in which the write strobe is high
  always @(negedge Clk) begin
    if (WR_STROBE === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_addr  = WR_ADDR;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of b, MSB first. MISO is sampled on each rise.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      SPI_MOSI = b[i];
      #Half;
      SPI_SCLK = 1'b1;
      miso[i] = SPI_MISO;
      #Half;
      SPI_SCLK = 1'b0;
    end
    #Half;
  endtask

  task automatic wr_loc(input logic [4:0] a, input logic [7:0] d);
    LOC_ADDR  = a;
    LOC_WDATA = d;
    LOC_WE    = 1'b1;
    @(negedge Clk);
    LOC_WE    = 1'b0;
  endtask

  task automatic rd_loc(input logic [4:0] a, output logic [7:0] d);
    LOC_ADDR = a;
    @(negedge Clk);
    @(negedge Clk);
    d = LOC_RDATA;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  initial begin
    logic [7:0] miso;
    logic [7:0] rd;
    int         base;
    logic       found;

    Reset_N   = 1'b0;
    SPI_CS_N  = 1'b1;
    SPI_SCLK  = 1'b0;
    SPI_MOSI  = 1'b0;
    LOC_ADDR  = '0;
    LOC_WDATA = '0;
    LOC_WE    = 1'b0;
    idle(3);
    chk("rst_miso", SPI_MISO, 0);
    chk("rst_oe", SPI_MISO_OE, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_strobe", WR_STROBE, 0);
    chk("rst_wr_addr", WR_ADDR, 0);
    chk("rst_rdata", LOC_RDATA, 0);
    Reset_N = 1'b1;
    idle(3);

    // SPI write 0x5A to reg 0x11
    base = strobe_cnt;
    SPI_CS_N = 1'b0;
    spi_bits(8'h8A, 8, miso);
    chk("wr_oe_active", SPI_MISO_OE, 1);
    chk("wr_status_miso", miso, 8'h00);
    spi_bits(8'h5A, 8, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("wr_strobe_cnt", strobe_cnt - base, 1);
    chk("wr_addr", last_addr, 5'h11);
    chk("wr_oe_off", SPI_MISO_OE, 0);
    chk("wr_miso_off", SPI_MISO, 0);
    rd_loc(5'h11, rd);
    chk("wr_rdata", rd, 8'h5A);

    // Read of reg3 with the status byte on MISO during the command byte
    wr_loc(5'd3, 8'hC3);
    wr_loc(5'd25, 8'h81);
    base = strobe_cnt;
    SPI_CS_N = 1'b0;
    spi_bits(8'h18, 8, miso);
    chk("rd_status", miso, 8'h81);
    spi_bits(8'h00, 8, miso);
    chk("rd_data", miso, 8'hC3);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("rd_no_strobe", strobe_cnt - base, 0);
    chk("rd_irq_masked", IRQ, 0);

    // Burst write to reg2
    base = strobe_cnt;
    SPI_CS_N = 1'b0;
    spi_bits(8'h12, 8, miso);
    chk("burst_status", miso, 8'h81);
    spi_bits(8'h01, 8, miso);
    spi_bits(8'h02, 8, miso);
    spi_bits(8'h03, 8, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("burst_strobes", strobe_cnt - base, 3);
    chk("burst_addr", last_addr, 5'h02);
    rd_loc(5'd2, rd);
    chk("burst_reg2", rd, 8'h03);

    // Abort after 4 data bits, then a clean transaction
    base = strobe_cnt;
    SPI_CS_N = 1'b0;
    spi_bits(8'h2A, 8, miso);
    spi_bits(8'hF0, 4, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("abort_no_strobe", strobe_cnt - base, 0);
    rd_loc(5'd5, rd);
    chk("abort_reg5", rd, 8'h00);
    SPI_CS_N = 1'b0;
    spi_bits(8'h2A, 8, miso);
    spi_bits(8'h77, 8, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("after_abort_strobe", strobe_cnt - base, 1);
    chk("after_abort_addr", last_addr, 5'h05);
    rd_loc(5'd5, rd);
    chk("after_abort_reg5", rd, 8'h77);

    // IRQ from status AND enable
    wr_loc(5'd26, 8'h04);
    @(negedge Clk);
    chk("irq_before", IRQ, 0);
    wr_loc(5'd25, 8'h04);
    @(negedge Clk);
    chk("irq_set", IRQ, 1);
    SPI_CS_N = 1'b0;
    spi_bits(8'hCA, 8, miso);
    chk("irq_status_miso", miso, 8'h04);
    spi_bits(8'h00, 8, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("irq_cleared", IRQ, 0);

    // Local write collides with the SPI commit to reg25; the SPI data must win
    SPI_CS_N = 1'b0;
    spi_bits(8'hCA, 8, miso);
    spi_bits(8'h3C, 7, miso);
    SPI_MOSI = 1'b0;
    #Half;
    LOC_ADDR  = 5'd25;
    LOC_WDATA = 8'h55;
    LOC_WE    = 1'b1;
    SPI_SCLK  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (WR_STROBE === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    LOC_WE = 1'b0;
    chk("collision_strobe_seen", found, 1);
    #Half;
    SPI_SCLK = 1'b0;
    #Half;
    SPI_CS_N = 1'b1;
    idle(6);
    rd_loc(5'd25, rd);
    chk("collision_reg25", rd, 8'h3C);
    chk("collision_irq", IRQ, 1);

    // Reset in the middle of a data byte
    SPI_CS_N = 1'b0;
    spi_bits(8'h8A, 8, miso);
    spi_bits(8'hA5, 3, miso);
    Reset_N = 1'b0;
    #1;
    chk("midrst_oe", SPI_MISO_OE, 0);
    chk("midrst_miso", SPI_MISO, 0);
    chk("midrst_irq", IRQ, 0);
    chk("midrst_rdata", LOC_RDATA, 0);
    chk("midrst_strobe", WR_STROBE, 0);
    chk("midrst_wr_addr", WR_ADDR, 0);
    @(negedge Clk);
    SPI_CS_N = 1'b1;
    idle(3);
    Reset_N = 1'b1;
    idle(3);
    rd_loc(5'h11, rd);
    chk("midrst_reg11", rd, 8'h00);
    rd_loc(5'd26, rd);
    chk("midrst_reg26", rd, 8'h00);
    base = strobe_cnt;
    SPI_CS_N = 1'b0;
    spi_bits(8'h8A, 8, miso);
    spi_bits(8'h99, 8, miso);
    SPI_CS_N = 1'b1;
    idle(6);
    chk("postrst_strobe", strobe_cnt - base, 1);
    rd_loc(5'h11, rd);
    chk("postrst_reg11", rd, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
